uart_tx_scheduler: RTL and testbench

APB master that brings up the UART after reset and then shares its transmit path between two byte-stream requesters. It programs the prescaler and control registers once, then round-robin arbitrates requesters, polls the UART status register until the TX FIFO is not full, and writes the granted byte to the TX data register. It sits between on-chip byte producers and the `EF_UART_APB` slave port on the same `PCLK` domain.

---
 rtl/uart_sched_pkg.sv | 29 ++
 rtl/apb_master_if.sv | 68 ++++++
 rtl/uart_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Purpose: shared types and register map for the UART TX scheduler and its APB master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_INIT_PR,
        ST_INIT_CTRL,
        ST_IDLE,
        ST_POLL,
        ST_WRITE
    } state_e;

    // One APB transfer request handed from the scheduler FSM to the APB master.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } apb_req_t;

    localparam logic [31:0] TXDATA_ADDR = 32'h0000_0000;
    localparam logic [31:0] PR_ADDR     = 32'h0000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_0008;
    localparam logic [31:0] CTRL_ADDR   = 32'h0000_000C;
    localparam logic [31:0] PR_INIT     = 32'd7;
    localparam logic [31:0] CTRL_INIT   = 32'h0000_0003;
    localparam int          TXFULL_BIT  = 0;

endpackage

// File: rtl/apb_master_if.sv
// Purpose: single-outstanding APB master; turns a start strobe into setup + access phases.
// Latency: setup the cycle after start, access next; done pulses on the PREADY cycle.
// Backpressure: access phase holds while PREADY is low; start is honoured only when idle or on done.
module apb_master_if
    import uart_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  apb_req_t    req_i,
    input  logic        pready_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic        done_o,
    output logic        idle_o
);

    logic     psel_q, psel_d;
    logic     penable_q, penable_d;
    apb_req_t req_q, req_d;
    logic     done;
    logic     idle;

    assign done = psel_q & penable_q & pready_i;
    assign idle = ~psel_q;

    // Phase sequencing: a start on the done cycle chains straight into the next setup phase.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        req_d     = req_q;
        if (start_i && (idle || done)) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            req_d     = req_i;
        end else if (psel_q && !penable_q) begin
            penable_d = 1'b1;
        end else if (done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
        end
    end

    // Phase and request registers; address/data held stable across setup and access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            req_q     <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            req_q     <= req_d;
        end
    end

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = req_q.write;
    assign paddr_o   = req_q.addr;
    assign pwdata_o  = req_q.wdata;
    assign done_o    = done;
    assign idle_o    = idle;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Purpose: brings up the UART over APB, then round-robins two byte requesters onto the TX data register.
// Latency: bring-up 4 cycles; 5 cycles per byte (accept, status poll, data write) with zero-wait APB.
// Backpressure: req_ready pulses only in IDLE; a full TX FIFO is re-polled, PREADY low stretches access.
module uart_tx_scheduler
    import uart_sched_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    output logic [1:0]  req_ready,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    output logic        init_done,
    output logic        busy,
    output logic        grant_id
);

    state_e     state_q, state_d;
    logic       init_done_q, init_done_d;
    logic       busy_q, busy_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [7:0] data_q, data_d;

    logic       winner;
    logic       apb_start;
    apb_req_t   apb_req;
    logic       apb_done;
    logic       apb_idle;
    logic       tx_full;
    logic       unused_prdata;

    assign tx_full       = PRDATA[TXFULL_BIT];
    assign unused_prdata = ^PRDATA;

    apb_master_if u_apb (
        .clk_i     (PCLK),
        .rst_ni    (PRESETn),
        .start_i   (apb_start),
        .req_i     (apb_req),
        .pready_i  (PREADY),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .paddr_o   (PADDR),
        .pwdata_o  (PWDATA),
        .done_o    (apb_done),
        .idle_o    (apb_idle)
    );

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        winner = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~last_q;
        end else if (req_valid[1]) begin
            winner = 1'b1;
        end
    end

    // Next-state and APB request generation; each transfer is launched on the done of the previous one.
    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        busy_d      = busy_q;
        grant_d     = grant_q;
        last_d      = last_q;
        data_d      = data_q;
        req_ready   = 2'b00;
        apb_start   = 1'b0;
        apb_req     = '{addr: STATUS_ADDR, write: 1'b0, wdata: 32'h0};
        unique case (state_q)
            ST_INIT_PR: begin
                apb_req = '{addr: PR_ADDR, write: 1'b1, wdata: PR_INIT};
                if (apb_idle) begin
                    apb_start = 1'b1;
                end
                if (apb_done) begin
                    state_d   = ST_INIT_CTRL;
                    apb_start = 1'b1;
                    apb_req   = '{addr: CTRL_ADDR, write: 1'b1, wdata: CTRL_INIT};
                end
            end
            ST_INIT_CTRL: begin
                if (apb_done) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready[winner] = 1'b1;
                    data_d            = winner ? req_data1 : req_data0;
                    grant_d           = winner;
                    busy_d            = 1'b1;
                    state_d           = ST_POLL;
                    apb_start         = 1'b1;
                end
            end
            ST_POLL: begin
                if (apb_done) begin
                    apb_start = 1'b1;
                    if (!tx_full) begin
                        state_d = ST_WRITE;
                        apb_req = '{addr: TXDATA_ADDR, write: 1'b1, wdata: {24'h0, data_q}};
                    end
                end
            end
            ST_WRITE: begin
                if (apb_done) begin
                    busy_d  = 1'b0;
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT_PR;
            end
        endcase
    end

    // State, held byte and arbitration history; reset discards any held byte and restarts bring-up.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_INIT_PR;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            data_q      <= data_d;
        end
    end

    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose: self-checking bench for uart_tx_scheduler with an APB transaction scoreboard.
// Latency: n/a.
// Backpressure: bench models PREADY wait states and a TX-full status sequence.
module tb_uart_tx_scheduler;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [7:0]  req_data0;
    logic [7:0]  req_data1;
    logic [1:0]  req_ready;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        init_done;
    logic        busy;
    logic        grant_id;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wd;
    } txn_t;

    txn_t exp_q[$];
    int   checks       = 0;
    int   errors       = 0;
    int   exp_pen      = 1;
    bit   ws_mode      = 1'b0;
    int   full_until   = 0;
    int   status_reads = 0;
    int   tx_writes    = 0;
    int   rdy_viol     = 0;

    uart_tx_scheduler dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .init_done (init_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
        txn_t t;
        t.addr = a;
        t.wr   = w;
        t.wd   = d;
        exp_q.push_back(t);
    endtask

    // APB slave model: PREADY wait states and status words, updated just after the rising edge.
    initial begin
        int acc;
        acc    = 0;
        PREADY = 1'b1;
        PRDATA = 32'h0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) acc++;
            else acc = 0;
            PREADY = !ws_mode || (acc >= 3);
            if (PSEL && !PENABLE && !PWRITE) begin
                PRDATA = (status_reads < full_until) ? 32'h1 : 32'h0;
                status_reads++;
            end
        end
    end

    // Monitor: pops the scoreboard on every completed APB transfer, sampled on the falling edge.
    initial begin
        int          pen_cnt;
        bit          unstable;
        logic [31:0] cap_addr;
        logic [31:0] cap_wd;
        logic        cap_wr;
        txn_t        e;
        pen_cnt  = 0;
        unstable = 1'b0;
        cap_addr = 32'h0;
        cap_wd   = 32'h0;
        cap_wr   = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) continue;
            if ((req_ready != 2'b00) && (busy || !init_done)) rdy_viol++;
            if (PSEL && !PENABLE) begin
                cap_addr = PADDR;
                cap_wr   = PWRITE;
                cap_wd   = PWDATA;
                pen_cnt  = 0;
                unstable = 1'b0;
            end else if (PSEL && PENABLE) begin
                pen_cnt++;
                if (PADDR !== cap_addr || PWRITE !== cap_wr || PWDATA !== cap_wd) unstable = 1'b1;
                if (PREADY) begin
                    if (PWRITE && PADDR == 32'h0) tx_writes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_apb: addr 0x%0h write %0d data 0x%0h, expected no transfer",
                                 PADDR, PWRITE, PWDATA);
                    end else begin
                        e = exp_q.pop_front();
                        chk("apb_addr", PADDR, e.addr);
                        chk("apb_write", {31'h0, PWRITE}, {31'h0, e.wr});
                        if (e.wr) chk("apb_wdata", PWDATA, e.wd);
                        chk("apb_stable", {31'h0, unstable}, 32'h0);
                        chk("penable_cycles", pen_cnt, exp_pen);
                    end
                end
            end
        end
    end

    task automatic send_byte(input int id, input logic [7:0] d, input int nfull, output int bc);
        int n;
        bit got;
        for (int i = 0; i <= nfull; i++) push_exp(32'h8, 1'b0, 32'h0);
        push_exp(32'h0, 1'b1, {24'h0, d});
        full_until = status_reads + nfull;
        @(posedge PCLK);
        #1;
        if (id == 0) req_data0 = d;
        else req_data1 = d;
        req_valid[id] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge PCLK);
            n++;
            if (req_ready[id]) got = 1'b1;
        end
        chk("accept_seen", {31'h0, got}, 32'h1);
        @(posedge PCLK);
        #1;
        req_valid[id] = 1'b0;
        chk("grant_id", {31'h0, grant_id}, id);
        bc = 0;
        @(negedge PCLK);
        while (busy && bc < 400) begin
            bc++;
            @(negedge PCLK);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int bc;
        int cyc;
        int n;
        int acc_n;
        int tx_before;
        int reads_before;
        bit got;

        PRESETn   = 1'b1;
        req_valid = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        #2 PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);

        chk("rst_psel", {31'h0, PSEL}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_req_ready", {30'h0, req_ready}, 32'h0);
        chk("rst_init_done", {31'h0, init_done}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_grant_id", {31'h0, grant_id}, 32'h0);

        // Bring-up: prescaler then control, init_done on cycle 5.
        push_exp(32'h4, 1'b1, 32'h7);
        push_exp(32'hC, 1'b1, 32'h3);
        PRESETn = 1'b1;
        cyc = 0;
        while (!init_done && cyc < 20) begin
            @(posedge PCLK);
            #1;
            cyc++;
            if (cyc == 1) begin
                chk("first_setup_psel", {31'h0, PSEL}, 32'h1);
                chk("first_setup_penable", {31'h0, PENABLE}, 32'h0);
            end
        end
        chk("init_done_cycle", cyc, 5);
        chk("bringup_drained", exp_q.size(), 0);

        // Single byte from requester 0.
        send_byte(0, 8'h55, 0, bc);
        chk("busy_single", bc, 4);

        // TX FIFO full for three polls on requester 1.
        reads_before = status_reads;
        send_byte(1, 8'h5A, 3, bc);
        chk("busy_full", bc, 10);
        chk("status_reads_full", status_reads - reads_before, 4);
        chk("req_ready_gated_full", rdy_viol, 0);

        // Arbitration: both requesters valid, expect A1, B2, A1, B2.
        for (int k = 0; k < 4; k++) begin
            push_exp(32'h8, 1'b0, 32'h0);
            push_exp(32'h0, 1'b1, (k % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        full_until = status_reads;
        @(posedge PCLK);
        #1;
        req_data0 = 8'hA1;
        req_data1 = 8'hB2;
        req_valid = 2'b11;
        acc_n = 0;
        n     = 0;
        while (acc_n < 4 && n < 200) begin
            @(negedge PCLK);
            n++;
            if ((req_ready & req_valid) != 2'b00) begin
                chk("rr_grant", {30'h0, req_ready}, (acc_n % 2 == 0) ? 32'h1 : 32'h2);
                acc_n++;
            end
        end
        @(posedge PCLK);
        #1;
        req_valid = 2'b00;
        chk("rr_accepts", acc_n, 4);
        n = 0;
        @(negedge PCLK);
        while (busy && n < 100) begin
            n++;
            @(negedge PCLK);
        end
        chk("rr_drained", exp_q.size(), 0);

        // Wait states: two PREADY-low cycles per transfer.
        ws_mode = 1'b1;
        exp_pen = 3;
        send_byte(0, 8'hC3, 0, bc);
        chk("busy_ws0", bc, 8);
        send_byte(1, 8'h3C, 0, bc);
        chk("busy_ws1", bc, 8);

        // Reset during the data-write access phase.
        push_exp(32'h8, 1'b0, 32'h0);
        full_until = status_reads;
        @(posedge PCLK);
        #1;
        req_data0 = 8'h99;
        req_valid = 2'b01;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge PCLK);
            n++;
            if (req_ready[0]) got = 1'b1;
        end
        chk("midrst_accept_seen", {31'h0, got}, 32'h1);
        @(posedge PCLK);
        #1;
        req_valid = 2'b00;
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge PCLK);
            n++;
            if (PSEL && PENABLE && PWRITE) got = 1'b1;
        end
        chk("midrst_write_access_seen", {31'h0, got}, 32'h1);
        tx_before = tx_writes;
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel", {31'h0, PSEL}, 32'h0);
        chk("midrst_penable", {31'h0, PENABLE}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_init_done", {31'h0, init_done}, 32'h0);
        ws_mode = 1'b0;
        exp_pen = 1;
        repeat (2) @(negedge PCLK);
        chk("midrst_scoreboard", exp_q.size(), 0);
        push_exp(32'h4, 1'b1, 32'h7);
        push_exp(32'hC, 1'b1, 32'h3);
        PRESETn = 1'b1;
        cyc = 0;
        while (!init_done && cyc < 20) begin
            @(posedge PCLK);
            #1;
            cyc++;
        end
        chk("rebringup_cycle", cyc, 5);
        repeat (12) @(negedge PCLK);
        chk("no_stale_write", tx_writes, tx_before);
        chk("rebringup_drained", exp_q.size(), 0);
        send_byte(1, 8'h77, 0, bc);
        chk("busy_after_reset", bc, 4);

        chk("req_ready_gated", rdy_viol, 0);
        chk("scoreboard_final", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
